// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : request FSM states (IDLE / WAIT / DROP)
//   NOP_INSTR     : default bubble instruction, addi x0,x0,0
//   fq_entry_t    : layout of one fetch-queue entry for the 32-bit build;
//                   the queue stores {pc, instr} with pc in the upper half.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, wdata     write one entry (ignored when full unless popping too)
//   pop, rdata      remove head entry; rdata always shows the head
//   clear           empty the queue; wins over push and pop
//   count           current occupancy (0..DEPTH)
//   empty, full     occupancy flags
module fetch_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a request/response instruction memory,
// a DEPTH-entry fetch queue, decode stall and redirect/flush.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   redirect_i, redirect_pc_i    taken branch/jump and its target; flushes fetch
//   stall_d_i                    decode not accepting; IF/ID register holds
//   imem_req_o, imem_addr_o      single-cycle request pulse and its address
//   imem_rvalid_i, imem_rdata_i  in-order response, >=1 cycle after request
//   valid_d_o, instr_d_o,
//   pc_d_o, pc_plus4_d_o         IF/ID pipeline register
//
// state | meaning
// IDLE  | no request outstanding; issue when the queue has room
// WAIT  | one request outstanding, its response will be kept
// DROP  | one request outstanding, its response will be discarded (flushed)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP      = XLEN'(NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_d_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_d_o,
  output logic [XLEN-1:0] instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus4_d_o
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   req_pc_q;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count;
  logic              q_empty;
  logic              q_full;
  logic [2*XLEN-1:0] head;

  // Room checks use the occupancy before any pop, so a response can always be
  // pushed even if decode stalls; this keeps stall_d_i out of the request path.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gating keeps the request low while reset is held.
        if (rst && !redirect_i && !q_full) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? IDLE : DROP;
        end else if (imem_rvalid_i) begin
          push = 1'b1;
          if ((count + CW'(1)) < DEPTH_C) issue = 1'b1;
          else                            state_d = IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        pc_q <= redirect_pc_i;
      end else if (issue) begin
        pc_q     <= pc_q + XLEN'(4);
        req_pc_q <= pc_q;
      end
    end
  end

  assign pop = !redirect_i && !q_empty && (!stall_d_i || !valid_d_o);

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_i),
    .wdata ({req_pc_q, imem_rdata_i}),
    .rdata (head),
    .count (count),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d_o    <= 1'b0;
      instr_d_o    <= NOP;
      pc_d_o       <= '0;
      pc_plus4_d_o <= '0;
    end else if (redirect_i) begin
      valid_d_o <= 1'b0;
      instr_d_o <= NOP;
    end else if (!stall_d_i || !valid_d_o) begin
      if (!q_empty) begin
        valid_d_o    <= 1'b1;
        pc_d_o       <= head[2*XLEN-1:XLEN];
        instr_d_o    <= head[XLEN-1:0];
        pc_plus4_d_o <= head[2*XLEN-1:XLEN] + XLEN'(4);
      end else begin
        valid_d_o <= 1'b0;
        instr_d_o <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Cycle 0 is the first cycle after reset
// release; inputs change 1 ns after the rising edge, outputs are sampled on
// the falling edge. The memory model answers each request with
// addr ^ 32'hA5A5_0000 after mem_wait wait states.
module tb_fetch_stage;

  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_d_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_d_o;
  logic [31:0] instr_d_o;
  logic [31:0] pc_d_o;
  logic [31:0] pc_plus4_d_o;

  int tests = 0;
  int fails = 0;
  int mem_wait = 0;

  logic        pend = 1'b0;
  int          cd = 0;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .NOP      (NOPI)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_d_i     (stall_d_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_d_o     (valid_d_o),
    .instr_d_o     (instr_d_o),
    .pc_d_o        (pc_d_o),
    .pc_plus4_d_o  (pc_plus4_d_o)
  );

  // Memory model: request captured mid-cycle, response driven after the edge.
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      pend = 1'b0;
      imem_rvalid_i = 1'b0;
    end else if (pend && cd == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = paddr ^ MASK;
      pend = 1'b0;
    end else begin
      imem_rvalid_i = 1'b0;
      if (pend) cd = cd - 1;
    end
    @(negedge clk);
    if (rst && imem_req_o) begin
      pend  = 1'b1;
      cd    = mem_wait;
      paddr = imem_addr_o;
    end
  end

  // Leaves the bench 1 ns into cycle 0 with reset released.
  task automatic do_reset(input int w);
    @(posedge clk); #1;
    rst = 1'b0; redirect_i = 1'b0; stall_d_i = 1'b0; redirect_pc_i = '0;
    mem_wait = w;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({valid_d_o, imem_req_o, instr_d_o, pc_d_o, pc_plus4_d_o} !== {1'b0, 1'b0, NOPI, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b req=%b instr=%h pc=%h pc4=%h, expected 0 0 %h 0 0",
               valid_d_o, imem_req_o, instr_d_o, pc_d_o, pc_plus4_d_o, NOPI);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ep;
    do_reset(0);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c == 0) begin
        tests++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
          fails++;
          $display("FAIL zw_first_req: got req=%b addr=%h, expected 1 00000000", imem_req_o, imem_addr_o);
        end
      end
      tests++;
      if (c < 3) begin
        if (valid_d_o !== 1'b0) begin
          fails++;
          $display("FAIL zw_early_valid c%0d: got %b, expected 0", c, valid_d_o);
        end
      end else begin
        ep = 32'(4 * (c - 3));
        if ({valid_d_o, pc_d_o, instr_d_o, pc_plus4_d_o} !== {1'b1, ep, ep ^ MASK, ep + 32'd4}) begin
          fails++;
          $display("FAIL zw_stream c%0d: got v=%b pc=%h instr=%h pc4=%h, expected pc=%h",
                   c, valid_d_o, pc_d_o, instr_d_o, pc_plus4_d_o, ep);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    logic er, ev;
    do_reset(3);
    for (int c = 0; c < 18; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      er = (c % 4 == 0);
      ev = (c >= 6) && ((c - 6) % 4 == 0);
      tests++;
      if ({imem_req_o, valid_d_o} !== {er, ev}) begin
        fails++;
        $display("FAIL ws_pattern c%0d: got req=%b valid=%b, expected %b %b", c, imem_req_o, valid_d_o, er, ev);
      end
      if (er) begin
        tests++;
        if (imem_addr_o !== 32'(c)) begin
          fails++;
          $display("FAIL ws_addr c%0d: got %h, expected %h", c, imem_addr_o, 32'(c));
        end
      end
      if (ev) begin
        tests++;
        if (pc_d_o !== 32'(c - 6)) begin
          fails++;
          $display("FAIL ws_pc c%0d: got %h, expected %h", c, pc_d_o, 32'(c - 6));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ep;
    logic        er;
    do_reset(0);
    for (int c = 0; c < 18; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      stall_d_i = (c >= 7 && c <= 11);
      @(negedge clk);
      er = !(c >= 9 && c <= 12);
      tests++;
      if (imem_req_o !== er) begin
        fails++;
        $display("FAIL stall_req c%0d: got %b, expected %b", c, imem_req_o, er);
      end
      if (c >= 3) begin
        if (c <= 7)       ep = 32'(4 * (c - 3));
        else if (c <= 12) ep = 32'h10;
        else              ep = 32'h14 + 32'(4 * (c - 13));
        tests++;
        if ({valid_d_o, pc_d_o, instr_d_o} !== {1'b1, ep, ep ^ MASK}) begin
          fails++;
          $display("FAIL stall_pc c%0d: got v=%b pc=%h instr=%h, expected pc=%h",
                   c, valid_d_o, pc_d_o, instr_d_o, ep);
        end
      end
    end
    stall_d_i = 1'b0;
  endtask

  task automatic test_redirect_wait();
    logic er, ev;
    logic [31:0] ea;
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      redirect_i    = (c == 1);
      redirect_pc_i = 32'h200;
      @(negedge clk);
      er = (c == 0 || c == 4 || c == 7);
      ea = (c == 0) ? 32'h0 : (c == 4) ? 32'h200 : 32'h204;
      ev = (c == 9);
      tests++;
      if ({imem_req_o, valid_d_o} !== {er, ev}) begin
        fails++;
        $display("FAIL rdw_pattern c%0d: got req=%b valid=%b, expected %b %b", c, imem_req_o, valid_d_o, er, ev);
      end
      if (er) begin
        tests++;
        if (imem_addr_o !== ea) begin
          fails++;
          $display("FAIL rdw_addr c%0d: got %h, expected %h", c, imem_addr_o, ea);
        end
      end
      if (ev) begin
        tests++;
        if ({pc_d_o, instr_d_o} !== {32'h200, 32'hA5A5_0200}) begin
          fails++;
          $display("FAIL rdw_target: got pc=%h instr=%h, expected 00000200 a5a50200", pc_d_o, instr_d_o);
        end
      end
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset(0);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      redirect_i    = (c == 5);
      redirect_pc_i = 32'h300;
      stall_d_i     = (c >= 5);
      if (c == 5) begin
        tests++;
        if (imem_rvalid_i !== 1'b1) begin
          fails++;
          $display("FAIL rrs_setup: rvalid got %b, expected 1 alongside redirect", imem_rvalid_i);
        end
      end
      @(negedge clk);
      case (c)
        6: begin
          tests++;
          if ({valid_d_o, instr_d_o, imem_req_o, imem_addr_o} !== {1'b0, NOPI, 1'b1, 32'h300}) begin
            fails++;
            $display("FAIL rrs_bubble: got v=%b instr=%h req=%b addr=%h, expected 0 %h 1 00000300",
                     valid_d_o, instr_d_o, imem_req_o, imem_addr_o, NOPI);
          end
        end
        7, 8: begin
          tests++;
          if ({valid_d_o, instr_d_o} !== {1'b0, NOPI}) begin
            fails++;
            $display("FAIL rrs_empty c%0d: got v=%b instr=%h, expected 0 %h", c, valid_d_o, instr_d_o, NOPI);
          end
        end
        9, 10: begin
          tests++;
          if ({valid_d_o, pc_d_o, instr_d_o} !== {1'b1, 32'h300, 32'hA5A5_0300}) begin
            fails++;
            $display("FAIL rrs_target c%0d: got v=%b pc=%h instr=%h, expected 1 00000300 a5a50300",
                     c, valid_d_o, pc_d_o, instr_d_o);
          end
        end
        default: ;
      endcase
    end
    stall_d_i = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset(0);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      redirect_i    = (c == 5);
      redirect_pc_i = 32'hFFFF_FFFC;
      @(negedge clk);
      case (c)
        6: begin
          tests++;
          if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin
            fails++;
            $display("FAIL wrap_req_top: got req=%b addr=%h, expected 1 fffffffc", imem_req_o, imem_addr_o);
          end
        end
        7: begin
          tests++;
          if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL wrap_req_zero: got req=%b addr=%h, expected 1 00000000", imem_req_o, imem_addr_o);
          end
        end
        9: begin
          tests++;
          if ({valid_d_o, pc_d_o, pc_plus4_d_o, instr_d_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h5A5A_FFFC}) begin
            fails++;
            $display("FAIL wrap_pc4: got v=%b pc=%h pc4=%h instr=%h, expected 1 fffffffc 00000000 5a5afffc",
                     valid_d_o, pc_d_o, pc_plus4_d_o, instr_d_o);
          end
        end
        10: begin
          tests++;
          if ({valid_d_o, pc_d_o, pc_plus4_d_o} !== {1'b1, 32'h0, 32'h4}) begin
            fails++;
            $display("FAIL wrap_next: got v=%b pc=%h pc4=%h, expected 1 00000000 00000004",
                     valid_d_o, pc_d_o, pc_plus4_d_o);
          end
        end
        default: ;
      endcase
    end
    redirect_i = 1'b0;
    // Mid-cycle reset while a request is outstanding: no clock edge involved.
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({valid_d_o, imem_req_o, instr_d_o, pc_d_o, pc_plus4_d_o} !== {1'b0, 1'b0, NOPI, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b req=%b instr=%h pc=%h pc4=%h, expected 0 0 %h 0 0",
               valid_d_o, imem_req_o, instr_d_o, pc_d_o, pc_plus4_d_o, NOPI);
    end
    @(negedge clk);
    tests++;
    if ({valid_d_o, imem_req_o} !== 2'b00) begin
      fails++;
      $display("FAIL reset_hold: got v=%b req=%b, expected 0 0", valid_d_o, imem_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
